// File: rtl/svm_classify_pkg.sv
// Shared fixed-point definitions for the HOG/SVM classifier.
//   FEA_I_DEF / FEA_F_DEF : default integer / fractional bits of a feature (Q4.8)
//   W_FRAC                : fractional bits of weights and bias (Q4.12)
//   ACC_FRAC              : fractional bits of products, accumulator and score
//   BIAS_SHL              : left shift aligning a Q4.12 bias to the accumulator
//   flags_t               : per-stage valid/first/last tags
//   sat_to_w()            : clamp a 64-bit signed value into a w-bit signed range
package svm_classify_pkg;

  localparam int FEA_I_DEF = 4;
  localparam int FEA_F_DEF = 8;
  localparam int W_FRAC    = 12;
  localparam int ACC_FRAC  = FEA_F_DEF + W_FRAC;
  localparam int BIAS_SHL  = ACC_FRAC - W_FRAC;
  localparam int SAT_W     = 64;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } flags_t;

  function automatic logic signed [SAT_W-1:0] sat_to_w(input logic signed [SAT_W-1:0] v,
                                                       input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/svm_classify_sat_add.sv
// Signed saturating adder: sum_o = clamp(a_i + b_i) to OUT_W signed bits.
// Operands are sign-extended to 64 bits so the raw sum never wraps
// (A_W and B_W must stay below 63).
//   a_i   : signed addend, A_W bits
//   b_i   : signed addend, B_W bits
//   sum_o : saturated signed sum, OUT_W bits
module sat_add
  import svm_classify_pkg::*;
#(
  parameter int A_W   = 40,
  parameter int B_W   = 29,
  parameter int OUT_W = 40
) (
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [OUT_W-1:0] sum_o
);

  logic signed [SAT_W-1:0] a_x;
  logic signed [SAT_W-1:0] b_x;

  assign a_x   = {{(SAT_W - A_W){a_i[A_W-1]}}, a_i};
  assign b_x   = {{(SAT_W - B_W){b_i[B_W-1]}}, b_i};
  assign sum_o = OUT_W'(sat_to_w(a_x + b_x, OUT_W));

endmodule

// File: rtl/svm_classify.sv
// Linear SVM window classifier: streams HOG features, multiplies each by a
// weight fetched from an external ROM, accumulates with saturation and adds
// the bias at the end of every window.
//   clk, rst          : clock, asynchronous active-low reset
//   fea, fea_valid    : unsigned Q(FEA_I).(FEA_F) feature and its strobe
//   win_start         : abort current window, next feature is index 0
//   w_addr, w_data    : weight ROM address / signed Q4.12 data (1-cycle read)
//   bias              : signed Q4.12 bias
//   score, detect     : signed window score (20 frac bits), score > 0
//   score_valid       : one-cycle pulse, 4 cycles after the last fea_valid
module svm_classify
  import svm_classify_pkg::*;
#(
  parameter  int FEA_I  = FEA_I_DEF,
  parameter  int FEA_F  = FEA_F_DEF,
  parameter  int W_W    = 16,
  parameter  int N_FEA  = 3780,
  parameter  int ACC_W  = 40,
  localparam int FEA_W  = FEA_I + FEA_F,
  localparam int AW     = (N_FEA > 1) ? $clog2(N_FEA) : 1,
  localparam int PROD_W = FEA_W + W_W + 1,
  localparam int BIAS_W = W_W + BIAS_SHL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FEA_W-1:0]        fea,
  input  logic                    fea_valid,
  input  logic                    win_start,
  output logic [AW-1:0]           w_addr,
  input  logic signed [W_W-1:0]   w_data,
  input  logic signed [W_W-1:0]   bias,
  output logic signed [ACC_W-1:0] score,
  output logic                    detect,
  output logic                    score_valid
);

  logic [AW-1:0]             idx_q, idx_d, idx_eff;
  logic                      at_first, at_last;
  logic [FEA_W-1:0]          fea_p1_q;
  flags_t                    flg_p1_q, flg_p2_q;
  logic signed [PROD_W-1:0]  fea_x, w_x, prod_d, prod_p2_q;
  logic signed [ACC_W-1:0]   acc_q, acc_in, acc_next, score_next, score_q;
  logic signed [BIAS_W-1:0]  bias_x;
  logic                      last_p3_q, detect_q, score_valid_q;

  // win_start forces index 0 in the same cycle so a coincident feature
  // fetches weight 0.
  always_comb begin
    idx_eff  = win_start ? '0 : idx_q;
    at_first = (idx_eff == '0);
    at_last  = (idx_eff == AW'(N_FEA - 1));
    idx_d    = idx_eff;
    if (fea_valid) idx_d = at_last ? '0 : idx_eff + AW'(1);
  end

  assign w_addr = idx_eff;

  assign fea_x  = {{(W_W + 1){1'b0}}, fea_p1_q};
  assign w_x    = {{(FEA_W + 1){w_data[W_W-1]}}, w_data};
  assign prod_d = fea_x * w_x;

  // A window's first product loads the accumulator, so a previous window
  // never leaks into the next one.
  assign acc_in = flg_p2_q.first ? '0 : acc_q;
  assign bias_x = {bias, {BIAS_SHL{1'b0}}};

  sat_add #(.A_W(ACC_W), .B_W(PROD_W), .OUT_W(ACC_W)) u_acc_add (
    .a_i   (acc_in),
    .b_i   (prod_p2_q),
    .sum_o (acc_next)
  );

  sat_add #(.A_W(ACC_W), .B_W(BIAS_W), .OUT_W(ACC_W)) u_bias_add (
    .a_i   (acc_q),
    .b_i   (bias_x),
    .sum_o (score_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q         <= '0;
      fea_p1_q      <= '0;
      flg_p1_q      <= '0;
      prod_p2_q     <= '0;
      flg_p2_q      <= '0;
      acc_q         <= '0;
      last_p3_q     <= 1'b0;
      score_q       <= '0;
      detect_q      <= 1'b0;
      score_valid_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      // S1: capture feature with its position tags
      if (fea_valid) fea_p1_q <= fea;
      flg_p1_q <= '{vld: fea_valid, first: at_first, last: at_last};
      // S2: product against the weight returned for that feature
      prod_p2_q <= prod_d;
      flg_p2_q  <= '{vld: flg_p1_q.vld & ~win_start,
                     first: flg_p1_q.first, last: flg_p1_q.last};
      // S3: saturating accumulate
      if (flg_p2_q.vld) acc_q <= acc_next;
      last_p3_q <= flg_p2_q.vld & flg_p2_q.last & ~win_start;
      // Score: completed sum plus aligned bias
      if (last_p3_q && !win_start) begin
        score_q  <= score_next;
        detect_q <= ~score_next[ACC_W-1] & (score_next != '0);
      end
      score_valid_q <= last_p3_q & ~win_start;
    end
  end

  assign score       = score_q;
  assign detect      = detect_q;
  assign score_valid = score_valid_q;

endmodule
